// File: rtl/store_align_buffer.sv
// Store alignment buffer. Takes right-justified store data from the memory
// stage and shifts it onto its byte lanes. It builds the byte write strobes,
// traps illegal stores, and queues legal stores in a DEPTH-entry FIFO that
// drains to the bus over a valid/ready handshake.
//
// in_type encoding (mem_t):
//   0 = MEM_SB, 1 = MEM_SH, 2 = MEM_SW, 3 = MEM_SD.
//   Codes 4..7 are not store types and are always rejected.
module store_align_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_W-1:0]         in_addr,
    input  logic [DATA_W-1:0]         in_wd,
    input  logic [2:0]                in_type,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_W-1:0]         out_addr,
    output logic [DATA_W-1:0]         out_wd,
    output logic [DATA_W/8-1:0]       out_strb,
    output logic                      misalign,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [2:0] MEM_SB = 3'd0;
    localparam logic [2:0] MEM_SH = 3'd1;
    localparam logic [2:0] MEM_SW = 3'd2;
    localparam logic [2:0] MEM_SD = 3'd3;

    // A store is legal when its access size fits the bus and is naturally aligned.
    function automatic logic is_legal(input logic [2:0] t, input logic [OFF_W-1:0] off);
        logic ok;
        case (t)
            MEM_SB:  ok = 1'b1;
            MEM_SH:  ok = (off[0] == 1'b0);
            MEM_SW:  ok = (off[1:0] == 2'b00);
            MEM_SD:  ok = (DATA_W == 64) && (off == '0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte enables: access-size mask shifted up to the byte offset.
    function automatic logic [STRB_W-1:0] lane_strb(input logic [2:0] t, input logic [OFF_W-1:0] off);
        logic [STRB_W-1:0] base;
        case (t)
            MEM_SB:  base = STRB_W'(1'b1);
            MEM_SH:  base = STRB_W'(2'b11);
            MEM_SW:  base = STRB_W'(4'hF);
            MEM_SD:  base = '1;
            default: base = '0;
        endcase
        return base << off;
    endfunction

    // Shift data onto its lanes and zero every byte the strobe does not enable.
    function automatic logic [DATA_W-1:0] lane_data(input logic [DATA_W-1:0] wd,
                                                    input logic [OFF_W-1:0]  off,
                                                    input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] shifted;
        logic [DATA_W-1:0] mask;
        shifted = wd << {off, 3'b000};
        for (int b = 0; b < STRB_W; b++) begin
            mask[8*b +: 8] = {8{strb[b]}};
        end
        return shifted & mask;
    endfunction

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_wd   [DEPTH];
    logic [STRB_W-1:0] mem_strb [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [CNT_W-1:0]  count_nxt;

    logic [OFF_W-1:0]  off_p0;
    logic              legal_p0;
    logic              vld_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [STRB_W-1:0] strb_p0;
    logic [DATA_W-1:0] wd_p0;
    logic              push;
    logic              pop;
    logic              head_fwd;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);

    // Request decode, alignment and FIFO bookkeeping for the coming edge.
    always_comb begin
        off_p0     = in_addr[OFF_W-1:0];
        legal_p0   = is_legal(in_type, off_p0);
        vld_p0     = in_valid && in_ready && !flush;
        push       = vld_p0 && legal_p0;
        pop        = out_valid && out_ready;
        strb_p0    = lane_strb(in_type, off_p0);
        wd_p0      = lane_data(in_wd, off_p0, strb_p0);
        addr_p0    = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        rd_ptr_nxt = rd_ptr + PTR_W'(pop);
        count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
        // The pushed entry becomes the head only when it is the sole occupant.
        head_fwd   = push && (wr_ptr == rd_ptr_nxt);
    end

    // Entry storage; slots are written only on a legal push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= addr_p0;
            mem_wd[wr_ptr]   <= wd_p0;
            mem_strb[wr_ptr] <= strb_p0;
        end
    end

    // Pointers, occupancy, trap pulse and the registered head presented to the bus.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            misalign <= 1'b0;
            out_addr <= '0;
            out_wd   <= '0;
            out_strb <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            misalign <= 1'b0;
        end else begin
            misalign <= vld_p0 && !legal_p0;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            if (count_nxt != '0) begin
                if (head_fwd) begin
                    out_addr <= addr_p0;
                    out_wd   <= wd_p0;
                    out_strb <= strb_p0;
                end else begin
                    out_addr <= mem_addr[rd_ptr_nxt];
                    out_wd   <= mem_wd[rd_ptr_nxt];
                    out_strb <= mem_strb[rd_ptr_nxt];
                end
            end
        end
    end

endmodule
